serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller that time-shares one instance of the team's single-bit FullAdder (a, b, ci -> s, co) over N clock cycles.
- Accepts two operands on a start pulse and shifts them LSB-first through the FullAdder, holding the carry in a flip-flop between cycles.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Serves as the sequencing layer between lab top-level switch/button logic and the combinational FullAdder datapath.

Parameters:
- N, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk, input, 1, single system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- start, input, 1, request pulse; sampled only in IDLE.
- a_in, input, N, operand A; captured on accepted start.
- b_in, input, N, operand B; captured on accepted start.
- busy, output, 1, high while in RUN.
- done, output, 1, one-cycle pulse when a result is valid.
- sum, output, N, registered result of the last completed operation.
- cout, output, 1, registered final carry of the last completed operation.

Behaviour:
- Reset (rst_n low, any time, asynchronous): state=IDLE; busy=0; done=0; sum=0; cout=0; operand shift registers, carry FF, and bit counter all cleared. Any in-flight operation is abandoned with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge: load a_sh<=a_in, b_sh<=b_in, carry<=0 (carry<=1 in SUB mode, see below), cnt<=0, and go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - The FullAdder is driven with a=a_sh[0], b=b_sh[0], ci=carry.
  - Each edge: carry<=co; a_sh and b_sh shift right by 1 (zero-fill MSB); the internal work register shifts right with s entering at bit N-1; cnt<=cnt+1.
  - When cnt==N-1 at an edge: sum<=completed work value (including this cycle's s), cout<=co, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally go to IDLE.
- Start handling: start is ignored in RUN and DONE; no queuing. The earliest next accept is the first IDLE cycle after DONE.
- Latency: start accepted at edge k -> busy high from k through k+N -> done high for the cycle after edge k+N.
- Operation period: minimum start-to-start is N+2 cycles.
- sum/cout change only on the RUN->DONE edge and hold until the next completion or reset. Intermediate work bits are never visible on sum.
- Arithmetic: result is (a_in + b_in) mod 2^N; cout is bit N of the true sum.
- Operand stability: a_in and b_in may change freely after the accepting edge without affecting the operation.
- start held high continuously: one operation every N+2 cycles, each using the operand values present at its accepting edge.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured with the operands on an accepted start.
  - If sub=1: b is inverted bit-wise on load and carry initialises to 1, so the result is (a_in - b_in) mod 2^N.
  - cout=1 means no borrow (a_in >= b_in unsigned).
  - If sub=0: behaviour is identical to the base block.
- When not defined: no sub port; carry always initialises to 0; addition only.

Test Plan:
- N=8, a_in=0x35, b_in=0x4A, 1-cycle start -> busy high for 8 cycles, then done pulse for 1 cycle; sum=0x7F, cout=0; done occurs 9 cycles after the accepting edge.
- a_in=0xFF, b_in=0x01 -> sum=0x00, cout=1. Then a_in=0x80, b_in=0x80 -> sum=0x00, cout=1. Then a_in=0x00, b_in=0x00 -> sum=0x00, cout=0.
- Start 0x12+0x34, then re-pulse start with a_in=0xFF, b_in=0xFF on RUN cycle 3 and again during DONE -> both ignored; sum=0x46, exactly one done pulse.
- Start 0xAA+0x55, assert rst_n=0 asynchronously mid-RUN (cnt=4) -> busy, done, sum, cout go to 0 immediately with no done pulse. After release, 0x01+0x02 gives sum=0x03.
- start held high with operands changed every cycle -> results match the operands present at each accepting edge, with done pulses exactly 10 cycles apart.
- With SERIAL_ADDER_SUB_EN defined:
  - sub=1, 0x10-0x01 -> sum=0x0F, cout=1.
  - sub=1, 0x01-0x02 -> sum=0xFF, cout=0.
  - sub=0, 0x10+0x01 -> sum=0x11.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one FullAdder is time-shared LSB-first over N cycles.
// Optional subtraction mode is enabled by defining SERIAL_ADDER_SUB_EN.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    logic [N-1:0]   r_a_sh;
    logic [N-1:0]   r_b_sh;
    logic [N-1:0]   r_work;
    logic [N-1:0]   r_sum;
    logic [CW-1:0]  r_cnt;
    logic           r_carry;
    logic           r_cout;
    logic           r_busy;
    logic           r_done;

    logic           w_s;
    logic           w_co;
    logic [N-1:0]   w_work_nxt;
    logic [N-1:0]   w_b_load;
    logic           w_c_load;

    // Subtraction is a + ~b + 1: invert b once at load and seed the carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub ? ~b_in : b_in;
    assign w_c_load = sub;
`else
    assign w_b_load = b_in;
    assign w_c_load = 1'b0;
`endif

    FullAdder u_fa (
        .a  (r_a_sh[0]),
        .b  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_work_nxt = {w_s, r_work[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a_in;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_co;
                    r_a_sh  <= {1'b0, r_a_sh[N-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[N-1:1]};
                    r_work  <= w_work_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                    // Final bit: publish the completed word, never a partial one.
                    if (r_cnt == LAST) begin
                        r_sum   <= w_work_nxt;
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule
